fetch_unit: RTL and testbench



---
 rtl/rv32i_pkg.sv | 14 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I pipeline types and constants
// Purpose: types shared across pipeline stages.
//   RESET_PC_DEFAULT : PC of the first fetch after reset
//   fetch_entry_t    : {pc, instr} pair handed from fetch to decode
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with flush
// Purpose: in-order buffer between instruction memory responses and decode.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push        : write i_push_data at the tail
//   i_pop         : drop the head entry
//   i_flush       : empty the queue; overrides push in the same cycle
//   o_head        : head entry (valid when !o_empty), straight from storage
//   o_count       : number of stored entries
//   o_full/o_empty: occupancy flags
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage
// Purpose: owns the PC, issues word fetches under a credit limit, buffers
// in-order responses, applies redirects (dropping wrong-path responses) and
// stops fetching after a halt until redirected.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_req_addr   : fetch request channel
//   imem_rsp_valid, imem_rsp_data         : in-order responses, no back-pressure
//   redirect_valid, redirect_pc           : flush and restart fetch
//   halt                                  : stop issuing new requests
//   if_valid/ready, if_instr, if_pc, if_pc4 : instruction to decode
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int            CW       = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   L_QDEPTH = (CW + 1)'(QDEPTH);

  logic [31:0]   r_pc;       // next sequential fetch address
  logic [31:0]   r_rsp_pc;   // fetch address of the next kept response
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic          r_halted;

  logic [31:0]   w_redirect_pc;
  logic          w_req_fire;
  logic          w_pop;
  logic          w_rsp_drop;
  logic          w_push;
  logic [CW:0]   w_credit_used;
  logic [CW-1:0] w_q_count;
  logic          w_q_full;
  logic          w_q_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_pop         = if_valid && if_ready;

  // Every in-flight request owns a queue slot, so a pop this cycle frees one.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_q_count} - {{CW{1'b0}}, w_pop};

  // A full queue that is not draining has no room regardless of inflight.
  assign imem_req_valid = !rst && !r_halted && (w_credit_used < L_QDEPTH)
                          && (!w_q_full || w_pop);
  assign imem_req_addr  = redirect_valid ? w_redirect_pc : r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the old stream.
  assign w_rsp_drop   = redirect_valid || (r_drop != '0);
  assign w_push       = imem_rsp_valid && !w_rsp_drop;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);

      // Everything still outstanding after this cycle's response is wrong-path;
      // a request accepted in the redirect cycle is already on the new path.
      if (redirect_valid)
        r_drop <= r_inflight - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (r_drop != '0))
        r_drop <= r_drop - CW'(1);

      if (w_req_fire)
        r_pc <= imem_req_addr + 32'd4;
      else if (redirect_valid)
        r_pc <= w_redirect_pc;

      // Kept responses are sequential from the last redirect target.
      if (redirect_valid)
        r_rsp_pc <= w_redirect_pc;
      else if (w_push)
        r_rsp_pc <= r_rsp_pc + 32'd4;

      if (redirect_valid)
        r_halted <= 1'b0;
      else if (halt)
        r_halted <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_head),
    .o_count    (w_q_count),
    .o_full     (w_q_full),
    .o_empty    (w_q_empty)
  );

  assign if_valid = !w_q_empty;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
  assign if_pc4   = w_head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (QD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  typedef struct {
    logic        req_ready;
    logic        if_rdy;
    logic        e_req_valid;
    logic [31:0] e_addr;
    logic        e_if_valid;
    logic [31:0] e_if_pc;
  } vec_t;

  mem_rsp_t    mq[$];
  vec_t        tbl[9];
  int          cyc, last_due, lat_min, lat_max;
  int          errors = 0;
  int          checks = 0;
  int          pops;
  logic [31:0] exp_pc, exp_fetch;
  logic        tb_halted;
  logic        prev_hold, prev_redir;
  logic [31:0] prev_pc, prev_instr;
  logic [31:0] watch_pc;
  logic        hit;
  logic        saw_wrap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit rsp_due();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First half of a cycle: memory presents a due response, then wait to the sampling edge.
  task automatic half_a();
    if (rsp_due()) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
  endtask

  // Second half: compare against the reference stream, update the memory model, advance.
  task automatic half_b();
    logic        fire;
    logic        pop;
    logic [31:0] tgt;
    int          lat, due;
    fire = imem_req_valid && imem_req_ready;
    pop  = if_valid && if_ready;
    tgt  = {redirect_pc[31:2], 2'b00};
    if (prev_hold && !prev_redir) begin
      chk("hold_valid", {31'b0, if_valid}, 32'd1);
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_instr", if_instr, prev_instr);
    end
    if (tb_halted) chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
    if (pop) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, mem_word(exp_pc));
      chk("if_pc4", if_pc4, exp_pc + 32'd4);
      if (if_pc == watch_pc) hit = 1'b1;
      if (exp_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_valid) begin
      exp_pc    = tgt;
      exp_fetch = tgt;
    end
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
    if (fire) begin
      exp_fetch = exp_fetch + 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due: due, data: mem_word(imem_req_addr)});
    end
    chk("outstanding", {31'b0, mq.size() <= QD}, 32'd1);
    if (imem_rsp_valid) void'(mq.pop_front());
    if (redirect_valid) tb_halted = 1'b0;
    else if (halt)      tb_halted = 1'b1;
    prev_hold  = if_valid && !if_ready;
    prev_pc    = if_pc;
    prev_instr = if_instr;
    prev_redir = redirect_valid;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    halt           = 1'b0;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_req_valid2", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    cyc        = 0;
    last_due   = -1;
    exp_pc     = 32'h0;
    exp_fetch  = 32'h0;
    tb_halted  = 1'b0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    lat_min    = 1;
    lat_max    = 1;
  endtask

  task automatic run_until(input logic [31:0] pc, input int budget, input string name);
    int n;
    watch_pc = pc;
    hit      = 1'b0;
    n        = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    pops     = 0;
    saw_wrap = 1'b0;
    watch_pc = 32'h1;
    hit      = 1'b0;

    // Startup with 1-cycle memory, then a 3-cycle decode stall.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      imem_req_ready = tbl[i].req_ready;
      if_ready       = tbl[i].if_rdy;
      half_a();
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_req_valid});
      if (tbl[i].e_req_valid) chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].e_if_valid});
      if (tbl[i].e_if_valid) chk($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].e_if_pc);
      half_b();
    end
    run_until(32'h40, 40, "stream_after_stall");

    // Redirect with two requests outstanding on a 3-cycle memory.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (mq.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("two_inflight", mq.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    run_until(32'h104, 40, "redir_inflight_resume");

    // Redirect in the same cycle as a response and a pop; low PC bits ignored.
    do_reset();
    repeat (4) tick();
    chk("redir_has_rsp", {31'b0, rsp_due()}, 32'd1);
    chk("redir_has_pop", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    tick();
    chk("redir_gap_empty", {31'b0, if_valid}, 32'd0);
    tick();
    chk("redir_2cyc_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_2cyc_pc", if_pc, 32'h200);
    run_until(32'h208, 20, "redir_same_cycle_resume");

    // Halt at 0x20, drain, then redirect (with a coincident halt) to 0x40.
    do_reset();
    n = 0;
    while (!(if_valid && if_pc == 32'h20) && n < 30) begin
      tick();
      n++;
    end
    chk("halt_point_reached", {31'b0, if_valid && if_pc == 32'h20}, 32'd1);
    halt = 1'b1;
    tick();
    repeat (6) tick();
    chk("halt_drained", {31'b0, if_valid}, 32'd0);
    chk("halt_mem_idle", mq.size(), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    halt           = 1'b1;
    run_until(32'h44, 20, "halt_resume");

    // Request stall, slow memory, and PC wrap at 2^32.
    do_reset();
    repeat (3) tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF0;
    tick();
    chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
    tick();
    tick();
    imem_req_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    saw_wrap = 1'b0;
    run_until(32'h4, 60, "wrap_resume");
    chk("wrap_seen", {31'b0, saw_wrap}, 32'd1);

    // Randomised traffic against the stream model.
    do_reset();
    lat_min = 1;
    lat_max = 4;
    pops    = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
      end
      if ($urandom_range(39, 0) == 0) halt = 1'b1;
      tick();
    end
    chk("random_progress", {31'b0, pops > 200}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
